// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, memory-wait stall and branch flush,
// plus saturating stall/interlock counters and a sticky memory-timeout flag.
module hazard_ctrl #(
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011,
  parameter int         MAX_WAIT    = 16,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [6:0]       ex_opcode,
  input  logic             ex_wr_reg_n,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             br_taken,
  output logic             stall,
  output logic             interlock,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] interlock_cycles
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MAX_WAIT - 1);
  localparam logic [WC_W-1:0] WAIT_MAX  = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, IL_HOLD} state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_il_cnt;

  logic w_load_use;
  logic w_stall;
  logic w_interlock;
  logic w_flush;

  // Mealy controls; all forced low while reset is asserted so a reset mid-wait releases at once
  always_comb begin
    w_load_use = (ex_opcode == LOAD_OPCODE) && !ex_wr_reg_n && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    w_stall     = 1'b0;
    w_interlock = 1'b0;
    if (rst_n) begin
      case (r_state)
        IDLE: begin
          w_stall     = mem_req && !mem_ack;
          w_interlock = w_load_use && !w_stall && !br_taken;
        end
        MEM_WAIT: w_stall = !mem_ack;
        IL_HOLD:  w_stall = mem_req && !mem_ack;
        default:  w_stall = 1'b0;
      endcase
    end
    w_flush = rst_n && br_taken && !w_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_il_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end else if (w_interlock) begin
            r_state <= IL_HOLD;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else begin
            if (r_wait_cnt == WAIT_LAST) r_timeout <= 1'b1;
            // hold the count once past the threshold; the flag is already sticky
            if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        IL_HOLD: begin
          if (w_stall) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_interlock && (r_il_cnt != {CNT_W{1'b1}})) r_il_cnt <= r_il_cnt + 1'b1;
    end
  end

  assign stall            = w_stall;
  assign interlock        = w_interlock;
  assign flush            = w_flush;
  assign mem_timeout      = r_timeout;
  assign stall_cycles     = r_stall_cnt;
  assign interlock_cycles = r_il_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls, a negedge monitor compares.
module tb_hazard_ctrl;
  localparam int CW = 4;
  localparam int MW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_wr_reg_n;
  logic [6:0]    ex_opcode;
  logic          mem_req, mem_ack, br_taken;
  logic          stall, interlock, flush, mem_timeout;
  logic [CW-1:0] stall_cycles, interlock_cycles;

  hazard_ctrl #(.LOAD_OPCODE(7'b0000011), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_wr_reg_n(ex_wr_reg_n),
    .mem_req(mem_req), .mem_ack(mem_ack), .br_taken(br_taken),
    .stall(stall), .interlock(interlock), .flush(flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .interlock_cycles(interlock_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic  st, il, fl, to;
    int    sc, ic;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   e_sc = 0;
  int   e_ic = 0;
  logic e_to = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_opcode = 7'b0010011; ex_wr_reg_n = 1'b1;
    mem_req = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
  endtask

  task automatic lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2, input logic wr_n);
    idle_in();
    ex_opcode = 7'b0000011; ex_rd = rd; ex_wr_reg_n = wr_n;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  task automatic expect_v(input string nm, input logic st, input logic il, input logic fl);
    exp_t e;
    e.nm = nm; e.st = st; e.il = il; e.fl = fl; e.to = e_to; e.sc = e_sc; e.ic = e_ic;
    q.push_back(e);
    if (st && e_sc < CMAX) e_sc++;
    if (il && e_ic < CMAX) e_ic++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_vec++;
      if (stall !== m_e.st || interlock !== m_e.il || flush !== m_e.fl || mem_timeout !== m_e.to ||
          int'(stall_cycles) != m_e.sc || int'(interlock_cycles) != m_e.ic) begin
        n_err++;
        $display("FAIL %s: got st=%0b il=%0b fl=%0b to=%0b sc=%0d ic=%0d, want st=%0b il=%0b fl=%0b to=%0b sc=%0d ic=%0d",
                 m_e.nm, stall, interlock, flush, mem_timeout, stall_cycles, interlock_cycles,
                 m_e.st, m_e.il, m_e.fl, m_e.to, m_e.sc, m_e.ic);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // reset held with every trigger active: controls must stay low
    lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    mem_req = 1'b1; br_taken = 1'b1;
    #2;
    chk("rst_outs", int'({stall, interlock, flush, mem_timeout}), 0);
    chk("rst_cnt", int'({stall_cycles, interlock_cycles}), 0);
    step(); expect_v("in_reset", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; idle_in();

    step(); idle_in(); expect_v("idle", 0, 0, 0);
    // load-use on rs1: one interlock cycle, then IL_HOLD suppresses it
    step(); lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); expect_v("lu_rs1", 0, 1, 0);
    step(); expect_v("lu_hold", 0, 0, 0);
    step(); idle_in(); expect_v("lu_done", 0, 0, 0);
    // no false hazards
    step(); lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); expect_v("rd_zero", 0, 0, 0);
    step(); lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1); expect_v("wr_off", 0, 0, 0);
    step(); lu(5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0); expect_v("rs2_unused", 0, 0, 0);
    step(); lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); ex_opcode = 7'b0110011; expect_v("not_load", 0, 0, 0);
    step(); lu(5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0); expect_v("lu_rs2", 0, 1, 0);
    step(); idle_in(); expect_v("rs2_hold", 0, 0, 0);
    // memory wait with ack on the 4th cycle
    for (int i = 0; i < 3; i++) begin
      step(); idle_in(); mem_req = 1'b1; expect_v("mem_wait", 1, 0, 0);
    end
    step(); mem_ack = 1'b1; expect_v("mem_ack", 0, 0, 0);
    step(); idle_in(); expect_v("mem_done", 0, 0, 0);
    // branch beats load-use; state must stay IDLE
    step(); lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); br_taken = 1'b1; expect_v("br_lu", 0, 0, 1);
    step(); lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); expect_v("lu_after_br", 0, 1, 0);
    step(); idle_in(); expect_v("lu_after_br_hold", 0, 0, 0);
    // branch during stall: flush deferred to the ack cycle
    step(); mem_req = 1'b1; br_taken = 1'b1; expect_v("br_stall", 1, 0, 0);
    step(); expect_v("br_stall2", 1, 0, 0);
    step(); mem_ack = 1'b1; expect_v("br_ack", 0, 0, 1);
    step(); idle_in(); expect_v("br_done", 0, 0, 0);
    // stall arriving while in IL_HOLD
    step(); lu(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); expect_v("lu_pre_mem", 0, 1, 0);
    step(); idle_in(); mem_req = 1'b1; expect_v("ilh_stall", 1, 0, 0);
    step(); mem_ack = 1'b1; expect_v("ilh_ack", 0, 0, 0);
    step(); idle_in(); mem_ack = 1'b1; expect_v("stray_ack", 0, 0, 0);
    step(); idle_in(); expect_v("after_stray", 0, 0, 0);
    // timeout: 20 unacked cycles, flag visible after the 16th, counter saturates
    for (int i = 1; i <= 20; i++) begin
      step(); idle_in(); mem_req = 1'b1; e_to = (i > MW); expect_v("timeout_wait", 1, 0, 0);
    end
    step(); mem_ack = 1'b1; expect_v("to_ack", 0, 0, 0);
    step(); idle_in(); expect_v("to_sticky", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; e_to = 1'b0; e_sc = 0; e_ic = 0;
    #2;
    chk("pulse_timeout", int'(mem_timeout), 0);
    @(negedge clk); rst_n = 1'b1;
    step(); idle_in(); expect_v("post_rst", 0, 0, 0);
    // asynchronous reset while in MEM_WAIT
    step(); mem_req = 1'b1; expect_v("pre_async", 1, 0, 0);
    step(); expect_v("pre_async2", 1, 0, 0);
    @(posedge clk); #2;
    chk("wait_stall", int'(stall), 1);
    rst_n = 1'b0; e_sc = 0; e_ic = 0;
    #1;
    chk("async_stall", int'(stall), 0);
    chk("async_cnt", int'({stall_cycles, interlock_cycles}), 0);
    @(negedge clk); rst_n = 1'b1; idle_in();
    step(); expect_v("after_async", 0, 0, 0);
    step(); mem_req = 1'b1; expect_v("re_wait", 1, 0, 0);
    step(); mem_ack = 1'b1; expect_v("re_ack", 0, 0, 0);
    step(); idle_in(); expect_v("re_done", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that generates the `stall`, `interlock` and `flush` controls consumed by the ID/EX (and IF/ID) pipeline registers.
- Detects load-use hazards between the ID-stage instruction and the instruction held in ID/EX.
- Holds the pipeline while the data memory has not acknowledged an access.
- Squashes younger instructions on a taken branch or jump.
- Keeps saturating stall/interlock cycle counters and a sticky memory-timeout flag for debug.

Parameters:
- LOAD_OPCODE, 7'b0000011, opcode value identifying loads in ID/EX.
- MAX_WAIT, 16, number of consecutive memory wait cycles before `mem_timeout` sets (≥2).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd held in ID/EX.
- ex_opcode  in  7  opcode held in ID/EX.
- ex_wr_reg_n  in  1  ID/EX register-write enable, active-low.
- mem_req  in  1  MEM stage is performing a data access; held until ack.
- mem_ack  in  1  data memory completes the access this cycle.
- br_taken  in  1  EX resolves a taken branch or jump this cycle.
- stall  out  1  freeze all pipeline registers.
- interlock  out  1  freeze IF/ID and ID/EX, bubble downstream.
- flush  out  1  invalidate IF/ID and ID/EX contents.
- mem_timeout  out  1  sticky error: memory wait reached MAX_WAIT.
- stall_cycles  out  CNT_W  count of cycles with `stall`=1.
- interlock_cycles  out  CNT_W  count of cycles with `interlock`=1.

Behaviour:
- Reset: `rst_n` low → state IDLE, `wait_cnt`=0, both counters 0, `mem_timeout`=0. `stall`, `interlock` and `flush` are forced 0 while `rst_n` is low. Reset mid-wait abandons the wait with no residual stall.
- Hazard term: `load_use` = (`ex_opcode`==LOAD_OPCODE) && !`ex_wr_reg_n` && (`ex_rd`!=0) && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
- Outputs are Mealy (combinational from state and inputs), 0-cycle latency. Counters and flags are registered.
- State IDLE:
  - `stall` = `mem_req` && !`mem_ack`.
  - `interlock` = `load_use` && !`stall` && !`br_taken`.
  - Next state: MEM_WAIT if `stall`; else IL_HOLD if `interlock`; else IDLE.
- State MEM_WAIT:
  - `stall` = !`mem_ack`; `interlock`=0.
  - `wait_cnt` starts at 1 on entry and increments each cycle without ack.
  - If `wait_cnt`==MAX_WAIT-1 and no ack, `mem_timeout`←1. `mem_timeout` stays set until reset. The stall continues regardless of timeout.
  - On `mem_ack`: `stall`=0 that cycle, `wait_cnt`←0, next state IDLE.
- State IL_HOLD:
  - `interlock`=0 unconditionally. This suppresses double detection; ID/EX clears its write enable during interlock, so the bubble resolves.
  - `stall` = `mem_req` && !`mem_ack`.
  - Next state: MEM_WAIT if `stall`, else IDLE.
- flush = `br_taken` && !`stall`, in any state. A branch coinciding with a stall produces no flush; EX holds `br_taken` and the flush occurs in the first cycle after the stall releases.
- Priority: `stall` > `flush` > `interlock`. `stall` and `interlock` are never both 1.
- Counters increment in any cycle where their output is 1 and saturate at all-ones, with no wrap.
- `mem_ack` without `mem_req` in IDLE is ignored.

Test Plan:
- Load-use hazard: ID/EX holds lw x5 (opcode 0000011, wr_reg_n=0, rd=5); ID has add with rs1=5, uses_rs1=1 → `interlock`=1 for exactly one cycle. Next cycle (IL_HOLD) `interlock`=0 even with inputs unchanged. `interlock_cycles`=1.
- No false hazard: same setup with rd=0, or with `ex_wr_reg_n`=1, or with rs2=5 but `uses_rs2`=0 → `interlock` stays 0 for all cycles.
- Memory wait: `mem_req`=1, `mem_ack` arriving on the 4th cycle → `stall`=1 for 3 cycles and 0 in the ack cycle. `stall_cycles`=3. State returns to IDLE. `mem_timeout`=0.
- Timeout: `mem_req`=1 with no ack for 20 cycles, MAX_WAIT=16 → `mem_timeout` rises after the 16th stall cycle, `stall` stays 1. After ack, `mem_timeout` remains 1 until `rst_n` pulses low.
- Simultaneous events:
  - load_use + `br_taken` in IDLE → `flush`=1, `interlock`=0.
  - `br_taken` + memory stall → `flush`=0 until the ack cycle, then `flush`=1.
- Async reset while in MEM_WAIT → `stall` drops immediately with no clock edge. Counters read 0 and state is IDLE after release.
